// File: rtl/alu_pkg.sv
// Shared ALU encodings: alu_control codes, RV32I opcodes and funct fields.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package alu_pkg;

  // alu_control encoding, also used by the execute block
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLL = 3'b101;

  // major opcodes of the supported subset
  localparam logic [6:0] OP_REG = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;

  // funct3 values
  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;

  // funct7 values
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // non-operand part of a decoded op
  typedef struct packed {
    logic [2:0] alu_control;
    logic [4:0] rd;
    logic       rd_we;
    logic       illegal;
  } dec_t;

endpackage

// File: rtl/alu_decode_stage_if.sv
// Decode-stage bundle: instruction handshake, decoded-op handshake, write-back port.
// Latency: n/a (wiring only).
// Backpressure: in_ready/out_ready carry the valid/ready handshakes.
interface alu_decode_stage_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic [2:0]      alu_control;
  logic [4:0]      rd;
  logic            rd_we;
  logic            illegal;
  logic            wb_en;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;

  // the decode stage itself
  modport slave (
    input  in_valid, in_instr, out_ready, wb_en, wb_rd, wb_data,
    output in_ready, out_valid, a, b, alu_control, rd, rd_we, illegal
  );

  // the environment: fetch, ALU and write-back sides
  modport master (
    output in_valid, in_instr, out_ready, wb_en, wb_rd, wb_data,
    input  in_ready, out_valid, a, b, alu_control, rd, rd_we, illegal
  );
endinterface

// File: rtl/alu_regfile.sv
// Integer register file, 2 combinational read ports, 1 write port, x0 reads zero.
// Latency: reads are combinational; writes land at the rising edge.
// Backpressure: none, writes are always accepted.
module alu_regfile #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   rs1_idx,
  input  logic [AW-1:0]   rs2_idx,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            we,
  input  logic [AW-1:0]   wr_idx,
  input  logic [XLEN-1:0] wr_data
);

  logic [XLEN-1:0] regs [NREGS];

  // clear every register on reset, then take write-backs except to x0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (wr_idx != '0)) begin
      regs[wr_idx] <= wr_data;
    end
  end

  // x0 is forced to zero on the read side, so entry 0 never matters
  always_comb begin
    rs1_data = (rs1_idx == '0) ? '0 : regs[rs1_idx];
    rs2_data = (rs2_idx == '0) ? '0 : regs[rs2_idx];
  end

endmodule

// File: rtl/alu_decode_stage.sv
// Decodes the RV32I ALU subset, reads/bypasses operands, registers them for the ALU.
// Latency: 1 cycle from accept to out_valid.
// Backpressure: in_ready = !out_valid || out_ready; outputs hold while stalled.
module alu_decode_stage
  import alu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_decode_stage_if.slave  bus
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [XLEN-1:0] rf_rs1;
  logic [XLEN-1:0] rf_rs2;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [XLEN-1:0] a_nxt;
  logic [XLEN-1:0] b_nxt;
  logic            legal;
  dec_t            dec;
  logic            accept;

  logic            out_valid_q;
  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] b_q;
  dec_t            dec_q;

  assign opcode = bus.in_instr[6:0];
  assign funct3 = bus.in_instr[14:12];
  assign funct7 = bus.in_instr[31:25];
  assign rs1    = bus.in_instr[19:15];
  assign rs2    = bus.in_instr[24:20];

  alu_regfile #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .rs1_idx  (rs1),
    .rs2_idx  (rs2),
    .rs1_data (rf_rs1),
    .rs2_data (rf_rs2),
    .we       (bus.wb_en),
    .wr_idx   (bus.wb_rd),
    .wr_data  (bus.wb_data)
  );

  // same-cycle write-back wins over the stored value; x0 is never bypassed
  always_comb begin
    rs1_val = (bus.wb_en && (bus.wb_rd == rs1) && (rs1 != 5'd0)) ? bus.wb_data : rf_rs1;
    rs2_val = (bus.wb_en && (bus.wb_rd == rs2) && (rs2 != 5'd0)) ? bus.wb_data : rf_rs2;
  end

  // decode the instruction word into op code, operands and flags
  always_comb begin
    legal           = 1'b0;
    dec.alu_control = ALU_ADD;
    a_nxt           = rs1_val;
    b_nxt           = rs2_val;
    case (opcode)
      OP_REG: begin
        case ({funct7, funct3})
          {F7_BASE, F3_ADD}: begin legal = 1'b1; dec.alu_control = ALU_ADD; end
          {F7_ALT,  F3_ADD}: begin legal = 1'b1; dec.alu_control = ALU_SUB; end
          {F7_BASE, F3_SLL}: begin legal = 1'b1; dec.alu_control = ALU_SLL; end
          {F7_BASE, F3_XOR}: begin legal = 1'b1; dec.alu_control = ALU_XOR; end
          {F7_BASE, F3_OR }: begin legal = 1'b1; dec.alu_control = ALU_OR;  end
          {F7_BASE, F3_AND}: begin legal = 1'b1; dec.alu_control = ALU_AND; end
          default: ;
        endcase
      end
      OP_IMM: begin
        b_nxt = {{(XLEN-12){bus.in_instr[31]}}, bus.in_instr[31:20]};
        case (funct3)
          F3_ADD: begin legal = 1'b1; dec.alu_control = ALU_ADD; end
          F3_XOR: begin legal = 1'b1; dec.alu_control = ALU_XOR; end
          F3_OR:  begin legal = 1'b1; dec.alu_control = ALU_OR;  end
          F3_AND: begin legal = 1'b1; dec.alu_control = ALU_AND; end
          F3_SLL: begin
            // shift amount is zero-extended, upper imm bits must be zero
            if (funct7 == F7_BASE) begin
              legal           = 1'b1;
              dec.alu_control = ALU_SLL;
              b_nxt           = {{(XLEN-5){1'b0}}, bus.in_instr[24:20]};
            end
          end
          default: ;
        endcase
      end
      default: ;
    endcase
    // illegal ops still flow down the pipe, but carry no operands or write-back
    if (!legal) begin
      dec.alu_control = ALU_ADD;
      a_nxt           = '0;
      b_nxt           = '0;
    end
    dec.rd      = bus.in_instr[11:7];
    dec.rd_we   = legal && (bus.in_instr[11:7] != 5'd0);
    dec.illegal = !legal;
  end

  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  // one-entry output register: load on accept, drain on consume
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      dec_q       <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      a_q         <= a_nxt;
      b_q         <= b_nxt;
      dec_q       <= dec;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.a           = a_q;
  assign bus.b           = b_q;
  assign bus.alu_control = dec_q.alu_control;
  assign bus.rd          = dec_q.rd;
  assign bus.rd_we       = dec_q.rd_we;
  assign bus.illegal     = dec_q.illegal;

endmodule

// File: doc/alu_decode_stage.md
# alu_decode_stage

Upstream operand stage for the `alu` execute block. It accepts RV32I instruction words over a valid/ready handshake and decodes the ALU subset: R-type ADD/SUB/AND/OR/XOR/SLL and I-type ADDI/ANDI/ORI/XORI/SLLI. It reads operands from a 32×32 integer register file, with x0 hardwired to zero and a write-back port bypassed into the read path. It presents `a`, `b` and `alu_control` from a one-entry registered output stage that drives the ALU directly.

## Interface
- `XLEN`, 32: operand and register width.
- `NREGS`, 32: register count. Index width is clog2(NREGS) = 5.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `in_valid` input 1: `in_instr` is valid.
- `in_ready` output 1: stage can accept this cycle.
- `in_instr` input 32: RV32I instruction word.
- `out_valid` output 1: output registers hold a decoded op.
- `out_ready` input 1: ALU side consumes the op this cycle.
- `a` output XLEN: operand A (rs1 value).
- `b` output XLEN: operand B (rs2 value, sign-extended imm, or zero-extended shamt).
- `alu_control` output 3: ALU op code.
- `rd` output 5: destination register index.
- `rd_we` output 1: write-back required (valid op with rd≠0).
- `illegal` output 1: instruction not in the supported subset.
- `wb_en` input 1: register-file write enable.
- `wb_rd` input 5: write index.
- `wb_data` input XLEN: write data.

## Operation
- `alu_control` codes:
  - 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLL.
  - 110 and 111 are never emitted.
- R-type decode (opcode 0110011):
  - funct3/funct7 000/0000000 → ADD; 000/0100000 → SUB.
  - 001/0000000 → SLL; 100/0000000 → XOR; 110/0000000 → OR; 111/0000000 → AND.
  - b = rs2 value.
- I-type decode (opcode 0010011):
  - funct3 000 → ADD; 100 → XOR; 110 → OR; 111 → AND. b = sign-extended instr[31:20].
  - funct3 001 with instr[31:25]=0000000 → SLL. b = {27'b0, instr[24:20]}.
- Illegal instruction (any other opcode/funct combination):
  - Captured like a normal op, with `illegal`=1.
  - alu_control=000, a=b=0, rd_we=0.
- Register file:
  - Reads of x0 return 0.
  - Writes to x0 are dropped.
  - Writes occur at the rising edge when `wb_en`=1.
- Bypass: on the acceptance cycle, if wb_en=1 and wb_rd equals a nonzero source index, that operand takes `wb_data`.
- Operands are captured at acceptance. They are not refreshed while the op is stalled in the output register; RAW hazards on in-flight ops are the pipeline controller's concern.

## Timing
- `in_ready` = !out_valid || out_ready (combinational; no skid buffer).
- Accept happens when in_valid && in_ready. The decoded op appears on the outputs the next cycle (latency 1).
- Full throughput: 1 op/cycle when out_ready is held high.
- Output registers hold stable while out_valid && !out_ready.
- out_valid:
  - Set on accept.
  - Cleared when the op is consumed with no new accept in the same cycle.
  - A simultaneous consume and accept keeps out_valid=1 and loads the new op.
- Reset (asynchronous, any time, including mid-stall):
  - out_valid=0, a=0, b=0, alu_control=000, rd=0, rd_we=0, illegal=0.
  - All registers x1..x31 = 0.
  - in_ready=1 immediately after reset deasserts.
- A write-back to a register in the same cycle as a later read of it is bypassed. A write-back in the cycle after acceptance is not seen by the op already captured.

## Structure
- Shared package `alu_pkg` holds:
  - the alu_control encoding constants (ALU_ADD..ALU_SLL);
  - opcode constants OP_REG=0110011 and OP_IMM=0010011;
  - funct3/funct7 constants.
  - The ALU block uses the same encoding constants.
- One sub-module, `alu_regfile`: 2 combinational read ports, 1 write port, x0 hardwired, async active-low reset. Bypass muxing stays in the parent.
- Decode is combinational in the parent, feeding the output register.

## Test plan
- Reset, then write x1=5 and x2=3 via wb. Issue `add x3,x1,x2` (0x002081B3) → next cycle a=5, b=3, alu_control=000, rd=3, rd_we=1.
- Issue `addi x4,x0,-1` (0xFFF00213) → a=0, b=0xFFFFFFFF, alu_control=000. Then issue `slli x5,x1,4` (0x00409293) → b=4, alu_control=101.
- Hold out_ready=0 for 3 cycles with in_valid=1 → in_ready=0 and outputs stable. Release → the next instruction loads in the same cycle as the consume, and out_valid stays 1.
- Accept `sub x6,x1,x2` (0x40208333) in the same cycle as wb x1=0x100 → a=0x100 (bypass), alu_control=001.
- Issue 0x00000073 (ecall) → illegal=1, rd_we=0, a=b=0. Issue `add x0,x1,x2` → rd_we=0.
- Assert rst_n=0 mid-stall with out_valid=1 → out_valid=0 asynchronously, and x1 reads 0 afterwards.
